sensor_frame_packetizer: RTL
============================

Name: sensor_frame_packetizer

Overview:
Upstream of the 16-to-32-bit ST packer in the sensor algorithm Qsys path. Captures N_SAMPLES free-running 16-bit ADC samples per frame trigger and buffers them in an internal FIFO. Emits each frame as a 16-bit Avalon-ST packet with SOP and EOP: 2-word header, then the samples. Every packet has an even word count, as the downstream packer requires.

Parameters:
N_SAMPLES, 256, samples per frame; must be even and >= 2.
FIFO_DEPTH, 512, sample FIFO depth in words; power of 2 and >= N_SAMPLES.
MAGIC, 16'hB5A1, header word 0 value.

Ports:
clk  in  1  clock
rst  in  1  reset
enable  in  1  permits trigger acceptance
adc_data  in  16  ADC sample
adc_valid  in  1  sample strobe; no backpressure to the ADC
frame_trig  in  1  single-cycle frame start pulse
out_data  out  16  ST source data
out_ready  in  1  ST sink ready
out_valid  out  1  ST valid
out_empty  out  1  always 0
out_startofpacket  out  1  high with header word 0
out_endofpacket  out  1  high with last word of packet
busy  out  1  capture in progress or packet output not in OUT_IDLE
missed_trig_cnt  out  16  saturating count of rejected triggers
frame_cnt  out  16  count of accepted triggers, wraps

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset clears all state. All outputs are 0 in reset, including the counters. FIFO is empty.
- Trigger acceptance (one cycle): frame_trig, enable, capture idle, and FIFO free space >= N_SAMPLES.
- On acceptance: frame_cnt++, pending_frames++, capture starts.
- Trigger rejection: a trigger with enable=1 that fails any acceptance condition increments missed_trig_cnt, saturating at 16'hFFFF.
- enable=0: triggers are ignored and not counted. Deasserting enable mid-frame does not abort the frame in progress.
- Capture: starts the cycle after acceptance. A sample coincident with the trigger is not captured. The next N_SAMPLES cycles with adc_valid=1 write adc_data to the FIFO, then capture returns to idle. Samples outside capture are discarded.
- Overflow cannot occur, because space is reserved at acceptance.
- Output FSM states: OUT_IDLE, HDR0, HDR1, DATA, and CRC/PAD with the optional feature.
- OUT_IDLE -> HDR0 when pending_frames > 0. pending_frames-- on this transition.
- pending_frames is incremented and decremented correctly when both happen in the same cycle.
- HDR0: out_data=MAGIC, out_valid=1, out_startofpacket=1.
- HDR1: out_data = the output side's own packet counter. This counter starts at 1 after reset and wraps. It equals the frame number because frames stay in order.
- DATA: out_data = FIFO head (show-ahead, valid in the same cycle), out_valid = FIFO not empty.
- Cut-through: DATA may drain while capture is still filling the same frame.
- DATA exits after N_SAMPLES words transferred. out_endofpacket=1 on sample N_SAMPLES-1.
- Transfer rule: a word transfers when out_valid && out_ready. State and data hold otherwise. out_valid never drops once asserted for a header word until that word transfers.
- Packet spacing: after EOP the FSM returns to OUT_IDLE, giving at least one idle cycle between packets.
- Packet length: 2+N_SAMPLES words, always even.
- Capture of frame k+1 may overlap draining of frame k if FIFO space allows.
- Simultaneous FIFO write and read in the same cycle is supported, including at full and empty boundaries.

Optional Feature:
PKT_CSUM_EN.
- Defined: after DATA the FSM emits CRC then PAD.
- CRC word = 16-bit wrapping sum of the frame's samples, accumulated on read.
- PAD word = 16'h0000, with out_endofpacket.
- Packet length = 4+N_SAMPLES words. EOP is not asserted in DATA.
- Undefined: no accumulator, no CRC/PAD states, behaviour exactly as above.

Test Plan:
- Basic frame: N_SAMPLES=4, out_ready=1, trigger, then samples 1,2,3,4 -> output B5A1(SOP), 0001, 1,2,3,4(EOP); frame_cnt=1; busy falls after EOP.
- Backpressure: out_ready toggles 1010..., adc gaps of 3 cycles -> identical word sequence, no duplicate or lost words, out_valid/out_data stable while out_ready=0.
- Rejection: FIFO_DEPTH=4, N_SAMPLES=4, out_ready=0, two triggers -> second rejected, missed_trig_cnt=1; with enable=0, triggers leave both counters unchanged.
- Back-to-back frames: FIFO_DEPTH=8, N_SAMPLES=4, second trigger during drain -> headers 0001 then 0002, each packet 6 words, at least one idle cycle between EOP and SOP.
- Reset mid-packet: assert rst during DATA -> all outputs 0 immediately; next trigger yields header word 1 = 0001 with a clean packet.
- PKT_CSUM_EN: samples FFFF,0002,0003,0004 -> CRC word 0008, PAD 0000 with EOP, 8 words total.

Source files
------------

// File: rtl/sensor_frame_packetizer.sv
// Frame packetizer: captures N_SAMPLES ADC samples per trigger into a FIFO and emits
// each frame as a 16-bit Avalon-ST packet (MAGIC, frame number, samples). Option: PKT_CSUM_EN.
module sensor_frame_packetizer #(
   parameter int unsigned N_SAMPLES  = 256,
   parameter int unsigned FIFO_DEPTH = 512,
   parameter logic [15:0] MAGIC      = 16'hB5A1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] adc_data,
   input  logic        adc_valid,
   input  logic        frame_trig,
   output logic [15:0] out_data,
   input  logic        out_ready,
   output logic        out_valid,
   output logic        out_empty,
   output logic        out_startofpacket,
   output logic        out_endofpacket,
   output logic        busy,
   output logic [15:0] missed_trig_cnt,
   output logic [15:0] frame_cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = $clog2(N_SAMPLES) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] NS_C    = CW'(N_SAMPLES);
   localparam logic [SW-1:0] LAST_C  = SW'(N_SAMPLES - 1);

`ifdef PKT_CSUM_EN
   typedef enum logic [2:0] {OUT_IDLE, HDR0, HDR1, DATA, CRC, PAD} out_state_e;
`else
   typedef enum logic [1:0] {OUT_IDLE, HDR0, HDR1, DATA} out_state_e;
`endif

   out_state_e    state_q, state_d;
   logic          cap_active_q, cap_active_d;
   logic [SW-1:0] cap_cnt_q, cap_cnt_d;
   logic [SW-1:0] rd_cnt_q, rd_cnt_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] pending_q, pending_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic [15:0]   missed_q, missed_d;
   logic [15:0]   pkt_cnt_q, pkt_cnt_d;
`ifdef PKT_CSUM_EN
   logic [15:0]   csum_q, csum_d;
`endif
   logic [15:0]   mem [FIFO_DEPTH];
   logic [CW-1:0] free_words;
   logic          fifo_wr, fifo_rd, pend_dec, trig_ok, trig_rej;

   // Output FSM; the DATA state reads the FIFO head directly (show-ahead)
   always_comb begin
      state_d           = state_q;
      rd_cnt_d          = rd_cnt_q;
      pkt_cnt_d         = pkt_cnt_q;
`ifdef PKT_CSUM_EN
      csum_d            = csum_q;
`endif
      out_data          = '0;
      out_valid         = 1'b0;
      out_startofpacket = 1'b0;
      out_endofpacket   = 1'b0;
      fifo_rd           = 1'b0;
      pend_dec          = 1'b0;
      case (state_q)
         OUT_IDLE: begin
            if (pending_q != '0) begin
               state_d  = HDR0;
               pend_dec = 1'b1;
            end
         end
         HDR0: begin
            out_data          = MAGIC;
            out_valid         = 1'b1;
            out_startofpacket = 1'b1;
            if (out_ready) state_d = HDR1;
         end
         HDR1: begin
            out_data  = pkt_cnt_q;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d   = DATA;
               pkt_cnt_d = pkt_cnt_q + 16'd1;
               rd_cnt_d  = '0;
`ifdef PKT_CSUM_EN
               csum_d    = '0;
`endif
            end
         end
         DATA: begin
            out_data  = mem[rd_ptr_q];
            out_valid = (count_q != '0);
`ifndef PKT_CSUM_EN
            out_endofpacket = out_valid && (rd_cnt_q == LAST_C);
`endif
            if (out_valid && out_ready) begin
               fifo_rd  = 1'b1;
               rd_cnt_d = rd_cnt_q + 1'b1;
`ifdef PKT_CSUM_EN
               csum_d   = csum_q + out_data;
               if (rd_cnt_q == LAST_C) state_d = CRC;
`else
               if (rd_cnt_q == LAST_C) state_d = OUT_IDLE;
`endif
            end
         end
`ifdef PKT_CSUM_EN
         CRC: begin
            out_data  = csum_q;
            out_valid = 1'b1;
            if (out_ready) state_d = PAD;
         end
         PAD: begin
            out_valid       = 1'b1;
            out_endofpacket = 1'b1;
            if (out_ready) state_d = OUT_IDLE;
         end
`endif
         default: state_d = OUT_IDLE;
      endcase
   end

   // Capture, FIFO bookkeeping and counters. Space is reserved at acceptance, so
   // the FIFO can never overflow while a frame is being captured.
   always_comb begin
      fifo_wr      = cap_active_q && adc_valid;
      free_words   = DEPTH_C - count_q;
      trig_ok      = frame_trig && enable && !cap_active_q && (free_words >= NS_C);
      trig_rej     = frame_trig && enable && !trig_ok;
      cap_active_d = cap_active_q;
      cap_cnt_d    = cap_cnt_q;
      wr_ptr_d     = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d     = fifo_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d      = count_q;
      pending_d    = pending_q;
      frame_cnt_d  = trig_ok ? frame_cnt_q + 16'd1 : frame_cnt_q;
      missed_d     = (trig_rej && (missed_q != '1)) ? missed_q + 16'd1 : missed_q;
      if (trig_ok) begin
         cap_active_d = 1'b1;
         cap_cnt_d    = '0;
      end else if (fifo_wr) begin
         cap_cnt_d = cap_cnt_q + 1'b1;
         if (cap_cnt_q == LAST_C) cap_active_d = 1'b0;
      end
      case ({fifo_wr, fifo_rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      case ({trig_ok, pend_dec})
         2'b10:   pending_d = pending_q + 1'b1;
         2'b01:   pending_d = pending_q - 1'b1;
         default: pending_d = pending_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= OUT_IDLE;
         cap_active_q <= 1'b0;
         cap_cnt_q    <= '0;
         rd_cnt_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         pending_q    <= '0;
         frame_cnt_q  <= '0;
         missed_q     <= '0;
         pkt_cnt_q    <= 16'd1;
`ifdef PKT_CSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cap_active_q <= cap_active_d;
         cap_cnt_q    <= cap_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         pending_q    <= pending_d;
         frame_cnt_q  <= frame_cnt_d;
         missed_q     <= missed_d;
         pkt_cnt_q    <= pkt_cnt_d;
`ifdef PKT_CSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) mem[wr_ptr_q] <= adc_data;
   end

   assign out_empty       = 1'b0;
   assign busy            = cap_active_q || (state_q != OUT_IDLE);
   assign missed_trig_cnt = missed_q;
   assign frame_cnt       = frame_cnt_q;

endmodule
